// File: rtl/freq_meas_gate_if.sv
// Measurement bus of freq_meas_gate: signal under test, run enable and the
// published per-window edge count with its update strobe.
interface freq_meas_gate_if #(
  parameter int COUNT_W = 24
);
  logic               test_clk;
  logic               fmeas_enable;
  logic [COUNT_W-1:0] fmeas_count;
  logic               fmeas_valid;

  modport master (
    output test_clk,
    output fmeas_enable,
    input  fmeas_count,
    input  fmeas_valid
  );

  modport slave (
    input  test_clk,
    input  fmeas_enable,
    output fmeas_count,
    output fmeas_valid
  );
endinterface

// File: rtl/freq_meas_gate.sv
// Gated frequency meter: counts synchronised test_clk rising edges per GATE_CYCLES window.
// Optional macro FREQ_MEAS_SATURATE_EN makes the edge counter saturate instead of wrap.
module freq_meas_gate #(
  parameter int unsigned GATE_CYCLES = 10_000_000,
  parameter int          COUNT_W     = 24,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  freq_meas_gate_if.slave        fm
);

  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;
  logic                   rise_p1;
  logic [31:0]            gate_cnt_p2;
  logic [COUNT_W-1:0]     edge_cnt_p2;
  logic [COUNT_W-1:0]     edge_next;

  function automatic logic [COUNT_W-1:0] edge_inc(input logic [COUNT_W-1:0] cnt,
                                                  input logic               hit);
`ifdef FREQ_MEAS_SATURATE_EN
    if (hit && (cnt != {COUNT_W{1'b1}}))
      return cnt + COUNT_W'(1);
    return cnt;
`else
    return cnt + COUNT_W'(hit);
`endif
  endfunction

  // Stage p0/p1: synchroniser chain plus history flop for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], fm.test_clk};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign rise_p1   = sync_p0[SYNC_STAGES-1] & ~hist_p1;
  assign edge_next = edge_inc(edge_cnt_p2, rise_p1);

  // Stage p2: gate window and edge accumulation; the last-cycle edge is folded into the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_cnt_p2    <= '0;
      edge_cnt_p2    <= '0;
      fm.fmeas_count <= '0;
      fm.fmeas_valid <= 1'b0;
    end else if (!fm.fmeas_enable) begin
      gate_cnt_p2    <= '0;
      edge_cnt_p2    <= '0;
      fm.fmeas_valid <= 1'b0;
    end else if (gate_cnt_p2 == GATE_LAST) begin
      gate_cnt_p2    <= '0;
      edge_cnt_p2    <= '0;
      fm.fmeas_count <= edge_next;
      fm.fmeas_valid <= 1'b1;
    end else begin
      gate_cnt_p2    <= gate_cnt_p2 + 32'd1;
      edge_cnt_p2    <= edge_next;
      fm.fmeas_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_meas_gate.sv
// Directed bench for freq_meas_gate: scoreboard of expected publications
// (count and cycle) checked whenever a result is due or a valid pulse appears.
module tb_freq_meas_gate;

  localparam int unsigned GATE_A = 1000;
  localparam int unsigned GATE_B = 100;
`ifdef FREQ_MEAS_SATURATE_EN
  localparam logic [23:0] EXP_OVF = 24'd15;
`else
  localparam logic [23:0] EXP_OVF = 24'd9;
`endif

  typedef struct {
    logic [23:0] cnt;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        tc = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb_a[$];
  exp_t        sb_b[$];

  int          half = 4;
  int          ph = 0;
  logic        hold = 1'b0;
  logic        hold_val = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  freq_meas_gate_if #(.COUNT_W(24)) if_a ();
  freq_meas_gate_if #(.COUNT_W(4))  if_b ();

  assign if_a.test_clk = tc;
  assign if_b.test_clk = tc;

  freq_meas_gate #(.GATE_CYCLES(GATE_A), .COUNT_W(24), .SYNC_STAGES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .fm    (if_a.slave)
  );

  freq_meas_gate #(.GATE_CYCLES(GATE_B), .COUNT_W(4), .SYNC_STAGES(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .fm    (if_b.slave)
  );

  // test_clk source, toggled on the falling clk edge with half-period 'half'
  always @(negedge clk) begin
    if (hold)
      tc = hold_val;
    else if (ph >= half - 1) begin
      ph = 0;
      tc = ~tc;
    end else
      ph = ph + 1;
  end

  always @(negedge clk) begin : mon_a
    logic exp_v;
    exp_t e;
    exp_v = (sb_a.size() > 0) && (sb_a[0].cyc == cyc);
    if (exp_v || (if_a.fmeas_valid !== 1'b0)) begin
      checks++;
      assert (if_a.fmeas_valid === exp_v)
      else begin
        errors++;
        $error("FAIL a_valid cyc=%0d got %b want %b", cyc, if_a.fmeas_valid, exp_v);
      end
      if (exp_v) begin
        e = sb_a.pop_front();
        checks++;
        assert (if_a.fmeas_count === e.cnt)
        else begin
          errors++;
          $error("FAIL a_count cyc=%0d got %0d want %0d", cyc, if_a.fmeas_count, e.cnt);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic exp_v;
    exp_t e;
    exp_v = (sb_b.size() > 0) && (sb_b[0].cyc == cyc);
    if (exp_v || (if_b.fmeas_valid !== 1'b0)) begin
      checks++;
      assert (if_b.fmeas_valid === exp_v)
      else begin
        errors++;
        $error("FAIL b_valid cyc=%0d got %b want %b", cyc, if_b.fmeas_valid, exp_v);
      end
      if (exp_v) begin
        e = sb_b.pop_front();
        checks++;
        assert (24'(if_b.fmeas_count) === e.cnt)
        else begin
          errors++;
          $error("FAIL b_count cyc=%0d got %0d want %0d", cyc, if_b.fmeas_count, e.cnt);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_a(input logic [23:0] c, input int unsigned at);
    sb_a.push_back('{cnt: c, cyc: at});
  endtask

  task automatic push_b(input logic [23:0] c, input int unsigned at);
    sb_b.push_back('{cnt: c, cyc: at});
  endtask

  initial begin : stim
    int unsigned en;

    // reset held with enable high and test_clk toggling
    reset = 1'b0;
    if_a.fmeas_enable = 1'b1;
    if_b.fmeas_enable = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk("rst_cnt_a", 32'(if_a.fmeas_count), 32'd0);
      chk("rst_vld_a", 32'(if_a.fmeas_valid), 32'd0);
    end
    chk("rst_cnt_b", 32'(if_b.fmeas_count), 32'd0);
    if_a.fmeas_enable = 1'b0;
    if_b.fmeas_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // basic count, period 8: three windows then drop enable 600 cycles into the fourth
    en = cyc;
    if_a.fmeas_enable = 1'b1;
    push_a(24'd125, en + GATE_A);
    push_a(24'd125, en + 2 * GATE_A);
    push_a(24'd125, en + 3 * GATE_A);
    wait_until(en + 3 * GATE_A + 600);
    if_a.fmeas_enable = 1'b0;
    wait_until(cyc + 1000);
    chk("hold_cnt", 32'(if_a.fmeas_count), 32'd125);
    chk("sb_a_basic", sb_a.size(), 32'd0);

    // re-enable: fresh window, result exactly GATE_A cycles later
    en = cyc;
    if_a.fmeas_enable = 1'b1;
    push_a(24'd125, en + GATE_A);
    wait_until(en + GATE_A + 5);
    if_a.fmeas_enable = 1'b0;
    chk("sb_a_reen", sb_a.size(), 32'd0);

    // fastest legal input (period 4) on A, overflow on the 4-bit B instance
    half = 2;
    repeat (40) @(negedge clk);
    en = cyc;
    if_a.fmeas_enable = 1'b1;
    if_b.fmeas_enable = 1'b1;
    push_a(24'd250, en + GATE_A);
    for (int k = 1; k <= 10; k++) push_b(EXP_OVF, en + GATE_B * k);
    wait_until(en + GATE_A + 5);
    if_a.fmeas_enable = 1'b0;
    if_b.fmeas_enable = 1'b0;
    chk("sb_a_fast", sb_a.size(), 32'd0);
    chk("sb_b_ovf", sb_b.size(), 32'd0);

    // static high input publishes zero
    hold_val = 1'b1;
    hold = 1'b1;
    repeat (40) @(negedge clk);
    en = cyc;
    if_a.fmeas_enable = 1'b1;
    push_a(24'd0, en + GATE_A);
    push_a(24'd0, en + 2 * GATE_A);
    wait_until(en + 2 * GATE_A + 5);
    if_a.fmeas_enable = 1'b0;
    chk("sb_a_static", sb_a.size(), 32'd0);

    // reset mid-window after a published result clears outputs asynchronously
    hold = 1'b0;
    half = 4;
    repeat (40) @(negedge clk);
    en = cyc;
    if_a.fmeas_enable = 1'b1;
    push_a(24'd125, en + GATE_A);
    push_a(24'd125, en + 2 * GATE_A);
    wait_until(en + GATE_A + 500);
    chk("pre_rst_cnt", 32'(if_a.fmeas_count), 32'd125);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(if_a.fmeas_count), 32'd0);
    chk("async_rst_vld", 32'(if_a.fmeas_valid), 32'd0);
    sb_a.delete();
    if_a.fmeas_enable = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (600) @(negedge clk);
    chk("post_rst_cnt", 32'(if_a.fmeas_count), 32'd0);
    chk("sb_a_end", sb_a.size(), 32'd0);
    chk("sb_b_end", sb_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
